cacheline_burst_adapter: RTL

Memory-side responder for the cache's line interface: accepts a 256-bit cacheline read or write request from the cache datapath/control (`ca_addr`, `ca_wdata`, `ca_rdata`, read/write strobes) and performs it on physical memory as a 4-beat, 64-bit burst. It sits between the cache (or the arbiter in front of it) and main memory. It assembles read beats into a full line and slices write lines into beats, then returns a single-cycle response to the cache.

---
 rtl/cacheline_pkg.sv | 17 +
 rtl/burst_line_buffer.sv | 41 ++++
 rtl/cacheline_burst_adapter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cacheline_pkg.sv
// cacheline_pkg: shared types and constants for the cacheline burst adapter.
//   cla_state_t - adapter FSM states (IDLE, READ, WRITE, DONE)
//   CL_BEATS    - beats per cacheline burst
//   CL_BEAT_W   - width of one burst beat in bits
package cacheline_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } cla_state_t;

   localparam int CL_BEATS  = 4;
   localparam int CL_BEAT_W = 64;

endpackage

// File: rtl/burst_line_buffer.sv
// burst_line_buffer: cacheline storage shared by read assembly and write slicing.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears the line)
//   load_en    - load the whole line from load_line (takes priority over beat_we)
//   beat_we    - write beat_in into beat slot beat_idx
//   beat_idx   - beat slot for both the per-beat write and the per-beat read mux
//   beat_out   - beat currently selected by beat_idx
//   line_out   - full stored line, beat 0 in the least significant bits
module burst_line_buffer
   import cacheline_pkg::*;
#(
   parameter int beat_w = CL_BEAT_W,
   parameter int beats  = CL_BEATS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_en,
   input  logic [beats*beat_w-1:0]   load_line,
   input  logic                      beat_we,
   input  logic [$clog2(beats)-1:0]  beat_idx,
   input  logic [beat_w-1:0]         beat_in,
   output logic [beat_w-1:0]         beat_out,
   output logic [beats*beat_w-1:0]   line_out
);

   logic [beats-1:0][beat_w-1:0] line_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
      end else if (load_en) begin
         line_q <= load_line;
      end else if (beat_we) begin
         line_q[beat_idx] <= beat_in;
      end
   end

   assign beat_out = line_q[beat_idx];
   assign line_out = line_q;

endmodule

// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: performs 256-bit cacheline reads/writes as 4-beat,
// 64-bit bursts on physical memory and returns a one-cycle response to the cache.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   ca_read, ca_write     - line request strobes from the cache (read wins if both)
//   ca_addr, ca_wdata     - request address (offset bits ignored) and write line
//   ca_rdata, ca_resp     - assembled read line and one-cycle completion pulse
//   pmem_read, pmem_write - burst strobes toward memory
//   pmem_addr             - line-aligned burst address
//   pmem_wdata            - current write beat
//   pmem_rdata, pmem_resp - current read beat and per-beat handshake
// Configuration macro:
//   CACHELINE_EARLY_RESP_EN - drop the DONE cycle; ca_resp fires combinationally
//                             on the last beat, with that beat bypassed into ca_rdata.
module cacheline_burst_adapter
   import cacheline_pkg::*;
#(
   parameter int s_offset = 5,
   parameter int s_burst  = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ca_read,
   input  logic         ca_write,
   input  logic [31:0]  ca_addr,
   input  logic [255:0] ca_wdata,
   output logic [255:0] ca_rdata,
   output logic         ca_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_addr,
   output logic [63:0]  pmem_wdata,
   input  logic [63:0]  pmem_rdata,
   input  logic         pmem_resp
);

   localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);

   cla_state_t     state;
   logic [1:0]     k;
   logic           busy;
   logic           last_beat;
   logic           load_en;
   logic           beat_we;
   logic [255:0]   line;

   assign busy      = (state == READ) || (state == WRITE);
   // pmem_resp is only meaningful while a burst is in flight
   assign last_beat = busy && pmem_resp && (k == 2'(CL_BEATS - 1));
   assign load_en   = (state == IDLE) && !ca_read && ca_write;
   assign beat_we   = (state == READ) && pmem_resp;

   burst_line_buffer #(
      .beat_w (s_burst),
      .beats  (CL_BEATS)
   ) u_line_buffer (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_en),
      .load_line (ca_wdata),
      .beat_we   (beat_we),
      .beat_idx  (k),
      .beat_in   (pmem_rdata),
      .beat_out  (pmem_wdata),
      .line_out  (line)
   );

`ifdef CACHELINE_EARLY_RESP_EN
   assign ca_resp  = last_beat;
   // the final read beat is not yet in the buffer, so bypass it
   assign ca_rdata = ((state == READ) && last_beat)
                     ? {pmem_rdata, line[255-CL_BEAT_W:0]} : line;
`else
   assign ca_rdata = line;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
         pmem_addr  <= '0;
`ifndef CACHELINE_EARLY_RESP_EN
         ca_resp    <= 1'b0;
`endif
      end else begin
`ifndef CACHELINE_EARLY_RESP_EN
         ca_resp <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (ca_read) begin
                  pmem_addr <= ca_addr & LINE_MASK;
                  k         <= '0;
                  pmem_read <= 1'b1;
                  state     <= READ;
               end else if (ca_write) begin
                  pmem_addr  <= ca_addr & LINE_MASK;
                  k          <= '0;
                  pmem_write <= 1'b1;
                  state      <= WRITE;
               end
            end
            READ, WRITE: begin
               if (pmem_resp) begin
                  k <= k + 2'd1;
                  if (last_beat) begin
                     pmem_read  <= 1'b0;
                     pmem_write <= 1'b0;
`ifdef CACHELINE_EARLY_RESP_EN
                     state      <= IDLE;
`else
                     state      <= DONE;
                     ca_resp    <= 1'b1;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
